// File: rtl/tdc_counter.sv
// rtl/tdc_counter.sv - pulse-width time-to-digital converter with word FIFO and basil bus registers
//
// Purpose:
//   Synchronizes the asynchronous TDC_IN into BUS_CLK, measures every high
//   pulse in BUS_CLK cycles and queues one 32-bit word per pulse:
//   {ID[3:0], WIDTH[11:0], EVENT_CNT[15:0]}. The queue feeds a readout
//   arbiter through a show-ahead FIFO interface.
//
// Ports:
//   BUS_CLK    in     1          only clock
//   BUS_RST    in     1          synchronous active-high reset
//   BUS_ADD    in     ABUSWIDTH  bus address
//   BUS_DATA   inout  8          bus data, driven for one cycle after a read
//   BUS_RD     in     1          bus read strobe
//   BUS_WR     in     1          bus write strobe
//   TDC_IN     in     1          asynchronous pulse input
//   FIFO_READ  in     1          pop strobe (arbiter READ_GRANT)
//   FIFO_EMPTY out    1          FIFO holds no words
//   FIFO_DATA  out    32         head word, valid while FIFO_EMPTY = 0
//
// Registers (offset from BASEADDR):
//   0  write: soft reset, read: version 8'd1
//   1  bit0 EN (R/W)
//   2  EVENT_CNT[7:0]   3  EVENT_CNT[15:8]   4  LOST_CNT
//   5..15 read 0, writes ignored

module tdc_counter #(
   parameter int unsigned          ABUSWIDTH = 32,
   parameter logic [ABUSWIDTH-1:0] BASEADDR  = 'h0200,
   parameter logic [ABUSWIDTH-1:0] HIGHADDR  = 'h020f,
   parameter int unsigned          DEPTH     = 16,
   parameter logic [3:0]           ID        = 4'h4
) (
   input  logic                 BUS_CLK,
   input  logic                 BUS_RST,
   input  logic [ABUSWIDTH-1:0] BUS_ADD,
   inout  wire  [7:0]           BUS_DATA,
   input  logic                 BUS_RD,
   input  logic                 BUS_WR,
   input  logic                 TDC_IN,
   input  logic                 FIFO_READ,
   output logic                 FIFO_EMPTY,
   output logic [31:0]          FIFO_DATA
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [7:0]  VERSION = 8'd1;

   // ---------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------
   logic                 in_range;
   logic [ABUSWIDTH-1:0] offset;
   logic                 wr_hit;
   logic                 soft_rst;
   logic                 rst;

   assign in_range = (BUS_ADD >= BASEADDR) && (BUS_ADD <= HIGHADDR);
   assign offset   = BUS_ADD - BASEADDR;
   assign wr_hit   = BUS_WR && in_range;
   assign soft_rst = wr_hit && (offset == ABUSWIDTH'(0));
   // Soft reset acts on the very edge of the write, exactly like BUS_RST.
   assign rst      = BUS_RST || soft_rst;

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   logic        en_q;
   logic        s1_q, s2_q, s3_q;
   logic        active_q, active_d;
   logic [11:0] width_q, width_d;
   logic [15:0] event_q;
   logic [7:0]  lost_q;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic [31:0]   mem_q [DEPTH];
   logic        rd_valid_q;
   logic [7:0]  rd_data_q;
   logic [7:0]  rd_mux;

   // ---------------------------------------------------------------
   // Edge detection and width measurement
   // ---------------------------------------------------------------
   logic rise, fall;
   logic push_req, push, pop;
   logic [31:0] word;

   assign rise     = s2_q && !s3_q;
   assign fall     = !s2_q && s3_q;
   assign push_req = active_q && en_q && fall;
   assign word     = {ID, width_q, event_q};

   always_comb begin
      active_d = active_q;
      width_d  = width_q;
      if (!en_q) begin
         // Disabling abandons a pulse in flight without touching counters.
         active_d = 1'b0;
      end else if (rise) begin
         active_d = 1'b1;
         width_d  = 12'd1;
      end else if (active_q) begin
         if (fall) begin
            active_d = 1'b0;
         end else if (s2_q && (width_q != 12'hFFF)) begin
            width_d = width_q + 12'd1;
         end
      end
   end

   // ---------------------------------------------------------------
   // FIFO control
   // ---------------------------------------------------------------
   // A full FIFO still accepts a push when the head leaves on the same
   // edge: the vacated slot is the one the write pointer targets.
   assign pop  = FIFO_READ && (count_q != '0);
   assign push = push_req && ((count_q < DEPTH_C) || pop);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   assign FIFO_EMPTY = (count_q == '0);
   assign FIFO_DATA  = mem_q[rd_ptr_q];

   always_ff @(posedge BUS_CLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= word;
      end
   end

   // ---------------------------------------------------------------
   // Register read mux
   // ---------------------------------------------------------------
   always_comb begin
      rd_mux = 8'd0;
      case (offset)
         ABUSWIDTH'(0): rd_mux = VERSION;
         ABUSWIDTH'(1): rd_mux = {7'd0, en_q};
         ABUSWIDTH'(2): rd_mux = event_q[7:0];
         ABUSWIDTH'(3): rd_mux = event_q[15:8];
         ABUSWIDTH'(4): rd_mux = lost_q;
         default:       rd_mux = 8'd0;
      endcase
   end

   // Read data is driven only in the cycle following the strobe.
   assign BUS_DATA = rd_valid_q ? rd_data_q : 8'bz;

   // ---------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------
   always_ff @(posedge BUS_CLK) begin
      if (rst) begin
         en_q       <= 1'b0;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
         active_q   <= 1'b0;
         width_q    <= 12'd0;
         event_q    <= 16'd0;
         lost_q     <= 8'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 8'd0;
      end else begin
         s1_q     <= TDC_IN;
         s2_q     <= s1_q;
         s3_q     <= s2_q;
         active_q <= active_d;
         width_q  <= width_d;
         count_q  <= count_d;

         if (wr_hit && (offset == ABUSWIDTH'(1))) begin
            en_q <= BUS_DATA[0];
         end

         // Every completed pulse gets an event number, dropped or not.
         if (push_req) begin
            event_q <= event_q + 16'd1;
         end
         if (push_req && !push && (lost_q != 8'hFF)) begin
            lost_q <= lost_q + 8'd1;
         end

         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end

         rd_valid_q <= BUS_RD && in_range;
         rd_data_q  <= rd_mux;
      end
   end

endmodule

// File: tb/tb_tdc_counter.sv
// tb/tb_tdc_counter.sv - directed self-checking bench for tdc_counter

module tb_tdc_counter;

   localparam logic [31:0] BASE = 32'h0200;

   logic        BUS_CLK = 1'b0;
   logic        BUS_RST = 1'b0;
   logic [31:0] BUS_ADD = 32'h0;
   wire  [7:0]  BUS_DATA;
   logic        BUS_RD = 1'b0;
   logic        BUS_WR = 1'b0;
   logic        TDC_IN = 1'b0;
   logic        FIFO_READ = 1'b0;
   logic        FIFO_EMPTY;
   logic [31:0] FIFO_DATA;

   logic        tb_drive = 1'b0;
   logic [7:0]  tb_data  = 8'h00;

   int tests  = 0;
   int failed = 0;

   assign BUS_DATA = tb_drive ? tb_data : 8'bz;

   always #5 BUS_CLK = ~BUS_CLK;

   tdc_counter #(
      .ABUSWIDTH(32),
      .BASEADDR (32'h0200),
      .HIGHADDR (32'h020f),
      .DEPTH    (16),
      .ID       (4'h4)
   ) dut (
      .BUS_CLK   (BUS_CLK),
      .BUS_RST   (BUS_RST),
      .BUS_ADD   (BUS_ADD),
      .BUS_DATA  (BUS_DATA),
      .BUS_RD    (BUS_RD),
      .BUS_WR    (BUS_WR),
      .TDC_IN    (TDC_IN),
      .FIFO_READ (FIFO_READ),
      .FIFO_EMPTY(FIFO_EMPTY),
      .FIFO_DATA (FIFO_DATA)
   );

   task automatic tick();
      @(posedge BUS_CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input int off, input logic [7:0] data);
      BUS_ADD  = BASE + 32'(off);
      tb_data  = data;
      tb_drive = 1'b1;
      BUS_WR   = 1'b1;
      tick();
      BUS_WR   = 1'b0;
      tb_drive = 1'b0;
   endtask

   task automatic bus_read(input int off, output logic [7:0] data);
      BUS_ADD = BASE + 32'(off);
      BUS_RD  = 1'b1;
      tick();
      BUS_RD  = 1'b0;
      data    = BUS_DATA;
      tick();
   endtask

   task automatic pulse(input int n);
      TDC_IN = 1'b1;
      repeat (n) tick();
      TDC_IN = 1'b0;
      repeat (4) tick();
   endtask

   task automatic pop();
      FIFO_READ = 1'b1;
      tick();
      FIFO_READ = 1'b0;
   endtask

   function automatic logic [31:0] exp_word(input int w, input int e);
      return {4'h4, 12'(w), 16'(e)};
   endfunction

   initial begin
      logic [7:0] rd;

      // Reset and register defaults
      BUS_RST = 1'b1;
      repeat (3) tick();
      BUS_RST = 1'b0;
      tick();
      check("reset_empty", 32'(FIFO_EMPTY), 32'd1);
      bus_read(0, rd); check("reg0_version", 32'(rd), 32'h01);
      bus_read(1, rd); check("reg1_en", 32'(rd), 32'h00);
      bus_read(2, rd); check("reg2_evt_lo", 32'(rd), 32'h00);
      bus_read(3, rd); check("reg3_evt_hi", 32'(rd), 32'h00);
      bus_read(4, rd); check("reg4_lost", 32'(rd), 32'h00);

      // Single 5-cycle pulse and its latency
      bus_write(1, 8'h01);
      bus_read(1, rd); check("en_set", 32'(rd), 32'h01);
      TDC_IN = 1'b1;
      repeat (5) tick();
      TDC_IN = 1'b0;
      tick(); // edge k: first low sample
      check("lat_k", 32'(FIFO_EMPTY), 32'd1);
      tick(); // edge k+1
      check("lat_k1", 32'(FIFO_EMPTY), 32'd1);
      tick(); // edge k+2: push
      check("lat_k2", 32'(FIFO_EMPTY), 32'd0);
      check("word_w5", FIFO_DATA, 32'h4005_0000);
      pop();
      check("pop_empty", 32'(FIFO_EMPTY), 32'd1);
      bus_read(2, rd); check("evt_after_1", 32'(rd), 32'h01);
      bus_read(3, rd); check("evt_hi_after_1", 32'(rd), 32'h00);

      // Fill: 20 pulses, widths 1..3, events 1..20
      for (int i = 0; i < 20; i++) pulse((i % 3) + 1);
      check("full_not_empty", 32'(FIFO_EMPTY), 32'd0);
      check("full_head", FIFO_DATA, exp_word(1, 1));
      bus_read(4, rd); check("lost_4", 32'(rd), 32'h04);
      bus_read(2, rd); check("evt_21", 32'(rd), 32'd21);

      // Full FIFO, pop coinciding with the push edge (width 7, event 21)
      TDC_IN = 1'b1;
      repeat (7) tick();
      TDC_IN = 1'b0;
      tick(); // k
      tick(); // k+1
      FIFO_READ = 1'b1;
      tick(); // k+2: push and pop together
      FIFO_READ = 1'b0;
      bus_read(4, rd); check("lost_unchanged", 32'(rd), 32'h04);
      bus_read(2, rd); check("evt_22", 32'(rd), 32'd22);

      // Drain: events 2..16 then the word from the coinciding push
      for (int i = 1; i < 16; i++) begin
         check("drain_nonempty", 32'(FIFO_EMPTY), 32'd0);
         check("drain_word", FIFO_DATA, exp_word((i % 3) + 1, i + 1));
         pop();
      end
      check("last_nonempty", 32'(FIFO_EMPTY), 32'd0);
      check("last_word", FIFO_DATA, exp_word(7, 21));
      pop();
      check("drained_empty", 32'(FIFO_EMPTY), 32'd1);

      // Pop while empty is ignored
      pop();
      check("empty_pop", 32'(FIFO_EMPTY), 32'd1);
      pulse(3);
      check("after_empty_pop", FIFO_DATA, exp_word(3, 22));
      pop();

      // Width saturation
      pulse(5000);
      check("sat_nonempty", 32'(FIFO_EMPTY), 32'd0);
      check("sat_word", FIFO_DATA, exp_word(12'hFFF, 23));
      pop();

      // EN cleared mid-pulse: no word, counters unchanged
      TDC_IN = 1'b1;
      repeat (10) tick();
      bus_write(1, 8'h00);
      repeat (5) tick();
      TDC_IN = 1'b0;
      repeat (6) tick();
      check("en_clr_empty", 32'(FIFO_EMPTY), 32'd1);
      bus_read(2, rd); check("en_clr_evt", 32'(rd), 32'd24);
      bus_read(4, rd); check("en_clr_lost", 32'(rd), 32'h04);

      // EN set while input already high: pulse ignored
      TDC_IN = 1'b1;
      repeat (5) tick();
      bus_write(1, 8'h01);
      repeat (5) tick();
      TDC_IN = 1'b0;
      repeat (6) tick();
      check("en_set_high_empty", 32'(FIFO_EMPTY), 32'd1);
      bus_read(2, rd); check("en_set_high_evt", 32'(rd), 32'd24);

      // Soft reset with 3 words queued and a pulse in flight
      pulse(2);
      pulse(2);
      pulse(2);
      check("pre_srst_nonempty", 32'(FIFO_EMPTY), 32'd0);
      TDC_IN = 1'b1;
      repeat (5) tick();
      bus_write(0, 8'hA5);
      check("srst_empty", 32'(FIFO_EMPTY), 32'd1);
      TDC_IN = 1'b0;
      repeat (6) tick();
      check("srst_no_word", 32'(FIFO_EMPTY), 32'd1);
      bus_read(1, rd); check("srst_en", 32'(rd), 32'h00);
      bus_read(2, rd); check("srst_evt_lo", 32'(rd), 32'h00);
      bus_read(3, rd); check("srst_evt_hi", 32'(rd), 32'h00);
      bus_read(4, rd); check("srst_lost", 32'(rd), 32'h00);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
